// File: rtl/ab_alu_datapath_pkg.sv
// Shared field positions and encodings for the address/PC datapath and its ALU.
package ab_alu_datapath_pkg;

    localparam int AB_W          = 13;
    localparam int AB_INC_PC     = 12;
    localparam int AB_LD_PC      = 11;
    localparam int AB_LD_AHL     = 10;
    localparam int AB_ABH_FF     = 9;
    localparam int AB_ABH_CSEL   = 8;   // abh_op[2]: carry from ADL vs abh_op[1]
    localparam int AB_ABH_BASE_L = 6;   // abh_op[1:0]
    localparam int AB_ABL_BASE_L = 4;   // abl_op[4:3]
    localparam int AB_ABL_OFF_L  = 2;   // abl_op[2:1]
    localparam int AB_ABL_RSVD   = 1;   // abl_op[0]
    localparam int AB_ABL_CI     = 0;

    typedef enum logic [1:0] {
        ABL_BASE_PCL  = 2'b00,
        ABL_BASE_ABL  = 2'b01,
        ABL_BASE_AHL  = 2'b10,
        ABL_BASE_ZERO = 2'b11
    } abl_base_e;

    typedef enum logic [1:0] {
        ABL_OFF_ZERO  = 2'b00,
        ABL_OFF_R     = 2'b01,
        ABL_OFF_DB    = 2'b10,
        ABL_OFF_ZERO2 = 2'b11
    } abl_off_e;

    typedef enum logic [1:0] {
        ABH_BASE_PCH  = 2'b00,
        ABH_BASE_DB   = 2'b01,
        ABH_BASE_ABH  = 2'b10,
        ABH_BASE_ZERO = 2'b11
    } abh_base_e;

    typedef enum logic [4:0] {
        ALU_OR   = 5'b00000,
        ALU_AND  = 5'b00001,
        ALU_XOR  = 5'b00010,
        ALU_ADD  = 5'b00011,
        ALU_SUB  = 5'b00100,
        ALU_PASR = 5'b00101,
        ALU_PASM = 5'b00110,
        ALU_SLM  = 5'b00111,
        ALU_SRM  = 5'b01000,
        ALU_SLR  = 5'b01001,
        ALU_SRR  = 5'b01010
    } alu_op_e;

endpackage

// File: rtl/ab_alu_datapath_if.sv
// Bus bundle between the sequencer (master) and the address/ALU datapath (slave).
interface ab_alu_datapath_if;
    logic [12:0] ab_op;
    logic [7:0]  DB;
    logic [7:0]  R;
    logic [7:0]  M;
    logic [4:0]  alu_op;
    logic        alu_ci;
    logic        alu_si;
    logic [15:0] AD;
    logic [7:0]  PCH;
    logic [7:0]  PCL;
    logic [7:0]  alu_out;
    logic        alu_co;
    logic        alu_v;
    logic        adjh;
    logic        adjl;

    modport master (
        output ab_op, DB, R, M, alu_op, alu_ci, alu_si,
        input  AD, PCH, PCL, alu_out, alu_co, alu_v, adjh, adjl
    );
    modport slave (
        input  ab_op, DB, R, M, alu_op, alu_ci, alu_si,
        output AD, PCH, PCL, alu_out, alu_co, alu_v, adjh, adjl
    );
endinterface

// File: rtl/ab_alu_datapath_alu_core.sv
// Combinational 8-bit ALU: logic ops, add/sub with overflow and BCD adjust hints, shifts.
module alu_core
    import ab_alu_datapath_pkg::*;
(
    input  logic [4:0] op_i,
    input  logic [7:0] r_i,
    input  logic [7:0] m_i,
    input  logic       ci_i,
    input  logic       si_i,
    output logic [7:0] out_o,
    output logic       co_o,
    output logic       v_o,
    output logic       adjh_o,
    output logic       adjl_o
);
    logic       is_sub;
    logic [7:0] b;
    logic [8:0] sum;
    logic       hc;

    assign is_sub = (op_i == ALU_SUB);
    assign b      = is_sub ? ~m_i : m_i;
    assign sum    = {1'b0, r_i} + {1'b0, b} + {8'd0, ci_i};
    // carry into bit 4 recovered from the sum bit, avoiding a second adder
    assign hc     = r_i[4] ^ b[4] ^ sum[4];

    always_comb begin
        out_o  = 8'h00;
        co_o   = 1'b0;
        v_o    = 1'b0;
        adjh_o = 1'b0;
        adjl_o = 1'b0;
        case (alu_op_e'(op_i))
            ALU_OR:   out_o = r_i | m_i;
            ALU_AND:  out_o = r_i & m_i;
            ALU_XOR:  out_o = r_i ^ m_i;
            ALU_ADD: begin
                out_o  = sum[7:0];
                co_o   = sum[8];
                v_o    = (r_i[7] == b[7]) & (r_i[7] != sum[7]);
                adjl_o = hc | (sum[3:0] > 4'd9);
                adjh_o = sum[8] | (sum[7:0] > 8'h99);
            end
            ALU_SUB: begin
                out_o  = sum[7:0];
                co_o   = sum[8];
                v_o    = (r_i[7] == b[7]) & (r_i[7] != sum[7]);
                adjl_o = ~hc;
                adjh_o = ~sum[8];
            end
            ALU_PASR: out_o = r_i;
            ALU_PASM: out_o = m_i;
            ALU_SLM:  begin out_o = {m_i[6:0], si_i}; co_o = m_i[7]; end
            ALU_SRM:  begin out_o = {si_i, m_i[7:1]}; co_o = m_i[0]; end
            ALU_SLR:  begin out_o = {r_i[6:0], si_i}; co_o = r_i[7]; end
            ALU_SRR:  begin out_o = {si_i, r_i[7:1]}; co_o = r_i[0]; end
            default:  ;
        endcase
    end
endmodule

// File: rtl/ab_alu_datapath.sv
// Address generator (ADL/ADH adders, AB/AHL latches), program counter, and ALU wrapper.
module ab_alu_datapath
    import ab_alu_datapath_pkg::*;
(
    input  logic               clk,
    input  logic               RST,
    ab_alu_datapath_if.slave   bus
);
    logic [7:0] abl_q, abh_q, ahl_q, pcl_q, pch_q;
    logic [7:0] abl_d, abh_d, ahl_d, pcl_d, pch_d;
    logic [7:0] adl_base, adl_off, adl, adh_base, adh;
    logic [7:0] pcl_src, pch_src;
    logic       abl_co, adh_ci, pcl_co;
    logic       unused_abl_rsvd;

    assign unused_abl_rsvd = bus.ab_op[AB_ABL_RSVD];

    always_comb begin
        adl_base = 8'h00;
        adl_off  = 8'h00;
        adh_base = 8'h00;
        case (abl_base_e'(bus.ab_op[AB_ABL_BASE_L+1:AB_ABL_BASE_L]))
            ABL_BASE_PCL:  adl_base = pcl_q;
            ABL_BASE_ABL:  adl_base = abl_q;
            ABL_BASE_AHL:  adl_base = ahl_q;
            ABL_BASE_ZERO: adl_base = 8'h00;
            default:       adl_base = 8'h00;
        endcase
        case (abl_off_e'(bus.ab_op[AB_ABL_OFF_L+1:AB_ABL_OFF_L]))
            ABL_OFF_R:  adl_off = bus.R;
            ABL_OFF_DB: adl_off = bus.DB;
            default:    adl_off = 8'h00;
        endcase
        case (abh_base_e'(bus.ab_op[AB_ABH_BASE_L+1:AB_ABH_BASE_L]))
            ABH_BASE_PCH:  adh_base = pch_q;
            ABH_BASE_DB:   adh_base = bus.DB;
            ABH_BASE_ABH:  adh_base = abh_q;
            ABH_BASE_ZERO: adh_base = 8'h00;
            default:       adh_base = 8'h00;
        endcase
    end

    assign {abl_co, adl} = {1'b0, adl_base} + {1'b0, adl_off} + {8'd0, bus.ab_op[AB_ABL_CI]};
    // abh_op[1] doubles as a constant carry when the ADL carry is not selected
    assign adh_ci = bus.ab_op[AB_ABH_CSEL] ? abl_co : bus.ab_op[AB_ABH_BASE_L+1];
    assign adh    = bus.ab_op[AB_ABH_FF] ? 8'hFF : adh_base + {7'd0, adh_ci};

    assign pcl_src         = bus.ab_op[AB_LD_PC] ? adl : pcl_q;
    assign pch_src         = bus.ab_op[AB_LD_PC] ? adh : pch_q;
    assign {pcl_co, pcl_d} = {1'b0, pcl_src} + {8'd0, bus.ab_op[AB_INC_PC]};
    assign pch_d           = pch_src + {7'd0, pcl_co};
    assign abl_d           = adl;
    assign abh_d           = adh;
    assign ahl_d           = bus.ab_op[AB_LD_AHL] ? bus.DB : ahl_q;

    always_ff @(posedge clk) begin
        if (RST) begin
            abl_q <= 8'h00;
            abh_q <= 8'h00;
            ahl_q <= 8'h00;
            pcl_q <= 8'h00;
            pch_q <= 8'h00;
        end else begin
            abl_q <= abl_d;
            abh_q <= abh_d;
            ahl_q <= ahl_d;
            pcl_q <= pcl_d;
            pch_q <= pch_d;
        end
    end

    assign bus.AD  = {adh, adl};
    assign bus.PCH = pch_q;
    assign bus.PCL = pcl_q;

    alu_core u_alu (
        .op_i   (bus.alu_op),
        .r_i    (bus.R),
        .m_i    (bus.M),
        .ci_i   (bus.alu_ci),
        .si_i   (bus.alu_si),
        .out_o  (bus.alu_out),
        .co_o   (bus.alu_co),
        .v_o    (bus.alu_v),
        .adjh_o (bus.adjh),
        .adjl_o (bus.adjl)
    );
endmodule

// File: tb/tb_ab_alu_datapath.sv
// Directed vectors for the address/PC datapath and the ALU, with hand-computed results.
module tb_ab_alu_datapath;
    logic clk = 1'b0;
    logic RST;
    int   n_vec = 0;
    int   n_err = 0;

    ab_alu_datapath_if bus();

    ab_alu_datapath dut (
        .clk (clk),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic inc, input logic ld, input logic ldahl,
                                       input logic ff, input logic [2:0] abh,
                                       input logic [1:0] base, input logic [1:0] off,
                                       input logic ci);
        return {inc, ld, ldahl, ff, abh, base, off, 1'b0, ci};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [12:0] op, input logic [7:0] db, input logic [7:0] r);
        bus.ab_op = op;
        bus.DB    = db;
        bus.R     = r;
        #1;
    endtask

    task automatic alu_t(input string tag, input logic [4:0] op, input logic [7:0] r,
                         input logic [7:0] m, input logic ci, input logic si,
                         input logic [7:0] e_out, input logic [3:0] e_flg);
        bus.alu_op = op;
        bus.R      = r;
        bus.M      = m;
        bus.alu_ci = ci;
        bus.alu_si = si;
        #1;
        // flags packed as {co, v, adjh, adjl}
        chk(tag, {4'h0, bus.alu_out, bus.alu_co, bus.alu_v, bus.adjh, bus.adjl},
            {4'h0, e_out, e_flg});
    endtask

    initial begin
        RST = 1'b1;
        bus.ab_op = '0; bus.DB = '0; bus.R = '0; bus.M = '0;
        bus.alu_op = '0; bus.alu_ci = 1'b0; bus.alu_si = 1'b0;
        step(); step();
        chk("rst_pc", {bus.PCH, bus.PCL}, 16'h0000);
        drive(mk(0,0,0,1,3'b000,2'b11,2'b01,0), 8'h00, 8'hFC);
        chk("rst_ad_comb", bus.AD, 16'hFFFC);

        RST = 1'b0;
        drive(mk(1,0,0,0,3'b000,2'b00,2'b00,0), 8'h00, 8'h00);
        chk("fetch_ad0", bus.AD, 16'h0000);
        step();
        chk("fetch_pc1", {bus.PCH, bus.PCL}, 16'h0001);
        chk("fetch_ad1", bus.AD, 16'h0001);
        step();
        chk("fetch_pc2", {bus.PCH, bus.PCL}, 16'h0002);

        drive(mk(0,1,0,0,3'b001,2'b11,2'b01,0), 8'h12, 8'hFF);
        chk("ldpc_ad", bus.AD, 16'h12FF);
        step();
        chk("ldpc_pc", {bus.PCH, bus.PCL}, 16'h12FF);
        drive(mk(1,0,0,0,3'b000,2'b00,2'b00,0), 8'h00, 8'h00);
        step();
        chk("pcl_carry", {bus.PCH, bus.PCL}, 16'h1300);

        drive(mk(0,0,1,0,3'b000,2'b00,2'b00,0), 8'hF0, 8'h00);
        step();
        drive(mk(0,0,0,0,3'b101,2'b10,2'b01,0), 8'h20, 8'h20);
        chk("idx_abs", bus.AD, 16'h2110);
        step();
        drive(mk(0,0,0,0,3'b110,2'b01,2'b00,0), 8'h00, 8'h00);
        chk("abreg_hold", bus.AD, 16'h2110);
        step();
        drive(mk(0,0,0,0,3'b010,2'b01,2'b00,1), 8'h00, 8'h00);
        chk("abreg_ci", bus.AD, 16'h2211);
        drive(mk(0,0,0,0,3'b100,2'b10,2'b10,1), 8'h10, 8'h00);
        chk("ahl_db_carry", bus.AD, 16'h1401);
        chk("pc_idle", {bus.PCH, bus.PCL}, 16'h1300);

        drive(mk(0,0,0,1,3'b000,2'b11,2'b01,0), 8'h00, 8'hFC);
        chk("vector", bus.AD, 16'hFFFC);
        drive(mk(1,1,0,1,3'b000,2'b11,2'b01,0), 8'h00, 8'hFC);
        step();
        chk("ldpc_inc", {bus.PCH, bus.PCL}, 16'hFFFD);

        RST = 1'b1;
        drive(mk(1,1,1,1,3'b000,2'b11,2'b01,0), 8'h55, 8'hFE);
        step();
        chk("rst_override_pc", {bus.PCH, bus.PCL}, 16'h0000);
        RST = 1'b0;
        drive(mk(0,0,0,0,3'b110,2'b01,2'b00,0), 8'h00, 8'h00);
        chk("rst_ab", bus.AD, 16'h0000);
        drive(mk(0,0,0,0,3'b011,2'b10,2'b00,0), 8'h00, 8'h00);
        chk("rst_ahl", bus.AD, 16'h0100);

        drive(mk(0,1,0,1,3'b000,2'b11,2'b01,0), 8'h00, 8'hFF);
        step();
        chk("ldpc_ffff", {bus.PCH, bus.PCL}, 16'hFFFF);
        drive(mk(1,0,0,0,3'b000,2'b00,2'b00,0), 8'h00, 8'h00);
        step();
        chk("pc_wrap", {bus.PCH, bus.PCL}, 16'h0000);

        alu_t("or",       5'b00000, 8'hF0, 8'h0F, 1'b0, 1'b0, 8'hFF, 4'b0000);
        alu_t("and",      5'b00001, 8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 4'b0000);
        alu_t("xor",      5'b00010, 8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 4'b0000);
        alu_t("add_ovf",  5'b00011, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 4'b0101);
        alu_t("sub_brw",  5'b00100, 8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 4'b0011);
        alu_t("add_adjl", 5'b00011, 8'h09, 8'h01, 1'b0, 1'b0, 8'h0A, 4'b0001);
        alu_t("add_adjh", 5'b00011, 8'h50, 8'h50, 1'b0, 1'b0, 8'hA0, 4'b0110);
        alu_t("add_co",   5'b00011, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 4'b1011);
        alu_t("sub_ok",   5'b00100, 8'h50, 8'h30, 1'b1, 1'b0, 8'h20, 4'b1000);
        alu_t("sub_ovf",  5'b00100, 8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 4'b1101);
        alu_t("pass_r",   5'b00101, 8'h5A, 8'hA5, 1'b1, 1'b1, 8'h5A, 4'b0000);
        alu_t("pass_m",   5'b00110, 8'h5A, 8'hA5, 1'b1, 1'b1, 8'hA5, 4'b0000);
        alu_t("slm",      5'b00111, 8'h00, 8'h81, 1'b0, 1'b0, 8'h02, 4'b1000);
        alu_t("srm",      5'b01000, 8'h00, 8'h81, 1'b0, 1'b1, 8'hC0, 4'b1000);
        alu_t("slr",      5'b01001, 8'h40, 8'h00, 1'b0, 1'b1, 8'h81, 4'b0000);
        alu_t("srr",      5'b01010, 8'h03, 8'h00, 1'b0, 1'b0, 8'h01, 4'b1000);
        alu_t("bad_0b",   5'b01011, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 4'b0000);
        alu_t("bad_1f",   5'b11111, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'h00, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
